// File: rtl/vga_pkg.sv
// XVGA (1024x768@60, 65 MHz) raster timing shared by the display driver and the
// sprite/background modules.
// No ports. Provides:
//   XVGA_* active/porch/sync/total constants and derived sync start/end positions,
//   SPRITE_PIPE_DEPTH, the latency from hcount/vcount to a composited pixel,
//   sync_t, the packed {hs, vs, blank} word carried through the delay line,
//   sync_start/sync_end helpers so every user derives boundaries the same way.
package vga_pkg;

   function automatic int unsigned sync_start(input int unsigned active,
                                              input int unsigned fp);
      return active + fp;
   endfunction

   // Last position (inclusive) of the sync pulse.
   function automatic int unsigned sync_end(input int unsigned start,
                                            input int unsigned width);
      return start + width - 1;
   endfunction

   localparam int unsigned XVGA_H_ACTIVE = 1024;
   localparam int unsigned XVGA_H_FP     = 24;
   localparam int unsigned XVGA_H_SYNC   = 136;
   localparam int unsigned XVGA_H_BP     = 160;
   localparam int unsigned XVGA_H_TOTAL  = XVGA_H_ACTIVE + XVGA_H_FP + XVGA_H_SYNC + XVGA_H_BP;

   localparam int unsigned XVGA_V_ACTIVE = 768;
   localparam int unsigned XVGA_V_FP     = 3;
   localparam int unsigned XVGA_V_SYNC   = 6;
   localparam int unsigned XVGA_V_BP     = 29;
   localparam int unsigned XVGA_V_TOTAL  = XVGA_V_ACTIVE + XVGA_V_FP + XVGA_V_SYNC + XVGA_V_BP;

   localparam int unsigned XVGA_HS_START = sync_start(XVGA_H_ACTIVE, XVGA_H_FP);
   localparam int unsigned XVGA_HS_END   = sync_end(XVGA_HS_START, XVGA_H_SYNC);
   localparam int unsigned XVGA_VS_START = sync_start(XVGA_V_ACTIVE, XVGA_V_FP);
   localparam int unsigned XVGA_VS_END   = sync_end(XVGA_VS_START, XVGA_V_SYNC);

   // Sprite ROM + palette ROM + output register.
   localparam int unsigned SPRITE_PIPE_DEPTH = 3;

   localparam int unsigned HCOUNT_W = 11;
   localparam int unsigned VCOUNT_W = 10;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } sync_t;

endpackage

// File: rtl/sync_delay.sv
// WIDTH x DEPTH shift register with synchronous reset to RESET_VAL.
// Ports:
//   clk_i   clock
//   rst_i   synchronous, active-high reset; every stage loads RESET_VAL
//   data_i  word entering stage 0
//   data_o  word leaving the last stage, DEPTH cycles after data_i
module sync_delay #(
   parameter int unsigned      WIDTH     = 3,
   parameter int unsigned      DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign stage_d[i] = data_i;
      end else begin : g_tail
         assign stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= {DEPTH{RESET_VAL}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_display_driver.sv
// Raster generator and VGA pin driver for the sprite pipeline.
// Ports:
//   pixel_clk_in      pixel clock (65 MHz for XVGA)
//   rst_in            synchronous, active-high reset
//   pixel_in          {R,G,B} 4:4:4 from the compositor, PIPE_DEPTH cycles after its address
//   hcount_out        horizontal position, 0..H_TOTAL-1
//   vcount_out        vertical position, 0..V_TOTAL-1
//   blank_out         undelayed blanking decode of the counters
//   vblank_start_out  one-cycle pulse at (0, V_ACTIVE); safe point for game-state updates
//   vga_r/g/b         colour to pins, forced to 0 while blanked
//   vga_hs/vga_vs     active-low syncs, aligned with colour
module vga_display_driver
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = XVGA_H_ACTIVE,
   parameter int unsigned H_FP       = XVGA_H_FP,
   parameter int unsigned H_SYNC     = XVGA_H_SYNC,
   parameter int unsigned H_BP       = XVGA_H_BP,
   parameter int unsigned V_ACTIVE   = XVGA_V_ACTIVE,
   parameter int unsigned V_FP       = XVGA_V_FP,
   parameter int unsigned V_SYNC     = XVGA_V_SYNC,
   parameter int unsigned V_BP       = XVGA_V_BP,
   parameter int unsigned PIPE_DEPTH = SPRITE_PIPE_DEPTH
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic [11:0] pixel_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        blank_out,
   output logic        vblank_start_out,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START_U = sync_start(H_ACTIVE, H_FP);
   localparam int unsigned VS_START_U = sync_start(V_ACTIVE, V_FP);

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START = 11'(HS_START_U);
   localparam logic [10:0] HS_END   = 11'(sync_end(HS_START_U, H_SYNC));
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START = 10'(VS_START_U);
   localparam logic [9:0]  VS_END   = 10'(sync_end(VS_START_U, V_SYNC));

   if (H_TOTAL > 2**HCOUNT_W || V_TOTAL > 2**VCOUNT_W) begin : g_bad_timing
      $error("vga_display_driver: raster totals exceed the 11/10-bit counters");
   end
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 7) begin : g_bad_depth
      $error("vga_display_driver: PIPE_DEPTH must be 1..7");
   end

   logic [10:0] hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic        blank;
   sync_t       raw, dly;
   logic        vga_hs_q, vga_hs_d;
   logic        vga_vs_q, vga_vs_d;
   logic [11:0] rgb_q, rgb_d;

   always_comb begin
      hcount_d = hcount_q + 11'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end
   end

   always_comb begin
      blank     = (hcount_q >= H_ACT) || (vcount_q >= V_ACT);
      raw.hs    = ~((hcount_q >= HS_START) && (hcount_q <= HS_END));
      raw.vs    = ~((vcount_q >= VS_START) && (vcount_q <= VS_END));
      raw.blank = blank;
   end

   // Reset value is "blanked, syncs inactive" so the pins stay dark until the
   // first address issued after reset reaches the output register.
   sync_delay #(
      .WIDTH    (3),
      .DEPTH    (PIPE_DEPTH),
      .RESET_VAL(3'b111)
   ) u_sync_delay (
      .clk_i (pixel_clk_in),
      .rst_i (rst_in),
      .data_i(raw),
      .data_o(dly)
   );

   always_comb begin
      vga_hs_d = dly.hs;
      vga_vs_d = dly.vs;
      rgb_d    = dly.blank ? 12'h000 : pixel_in;
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         hcount_q <= '0;
         vcount_q <= '0;
         vga_hs_q <= 1'b1;
         vga_vs_q <= 1'b1;
         rgb_q    <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         vga_hs_q <= vga_hs_d;
         vga_vs_q <= vga_vs_d;
         rgb_q    <= rgb_d;
      end
   end

   assign hcount_out       = hcount_q;
   assign vcount_out       = vcount_q;
   assign blank_out        = blank;
   assign vblank_start_out = (hcount_q == '0) && (vcount_q == V_ACT);
   assign vga_r            = rgb_q[11:8];
   assign vga_g            = rgb_q[7:4];
   assign vga_b            = rgb_q[3:0];
   assign vga_hs           = vga_hs_q;
   assign vga_vs           = vga_vs_q;

endmodule
